// File: rtl/fib_pkg.sv
// Shared definitions for the multi-channel Fibonacci Wishbone peripheral:
// register byte offsets, default ID value and channel-count limits.
package fib_pkg;

    localparam logic [7:0] OFF_ID       = 8'h00;
    localparam logic [7:0] OFF_INFO     = 8'h04;
    localparam logic [7:0] OFF_CTRL     = 8'h08;
    localparam logic [7:0] OFF_STEP     = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h10;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h14;
    localparam logic [7:0] OFF_OUTSEL   = 8'h18;
    localparam logic [7:0] OFF_VAL      = 8'h20;

    localparam logic [31:0] ID_DEFAULT = 32'h4669_626f;

    localparam int MAX_NCH  = 8;
    localparam int OUTSEL_W = $clog2(MAX_NCH);

endpackage

// File: rtl/fib_wb_multi_if.sv
// Wishbone slave bundle for the Fibonacci peripheral.
// Ports: stb/cyc/we/sel/dat_i/adr from master; ack/dat_o from slave.
interface fib_wb_multi_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/fib_channel.sv
// One Fibonacci generator: a is the visible term, b the next term (one
// extra bit so overflow of the visible width can be detected).
// Ports: clk, reset, advance, restart in; a (current term), ovf_pulse out.
module fib_channel #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             restart,
    output logic [WIDTH-1:0] a,
    output logic             ovf_pulse
);

    logic [WIDTH:0] b;

    // The next term no longer fits: this advance wraps instead.
    assign ovf_pulse = advance & ~restart & b[WIDTH];

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            a <= '0;
            b <= {{WIDTH{1'b0}}, 1'b1};
        end else if (advance) begin
            if (b[WIDTH]) begin
                a <= '0;
                b <= {{WIDTH{1'b0}}, 1'b1};
            end else begin
                a <= b[WIDTH-1:0];
                b <= {1'b0, a} + b;
            end
        end
    end

endmodule

// File: rtl/fib_wb_multi.sv
// NCH-channel Fibonacci generator with a Wishbone register window.
// Ports: clk, reset, wbs (Wishbone slave), irq_o, value_o, run_o.
module fib_wb_multi
    import fib_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          NCH          = 4,
    parameter int          WIDTH        = 32,
    parameter logic [31:0] ID           = ID_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    fib_wb_multi_if.slave     wbs,
    output logic              irq_o,
    output logic [WIDTH-1:0]  value_o,
    output logic [NCH-1:0]    run_o
);

    logic                ack_q;
    logic [31:0]         dat_q;
    logic [NCH-1:0]      run_q;
    logic [NCH-1:0]      irq_en_q;
    logic [NCH-1:0]      stat_q;
    logic [OUTSEL_W-1:0] outsel_q;

    logic        hit;
    logic        accept;
    logic        wr_en;
    logic [7:0]  off;
    logic [31:0] wdat;
    logic        val_hit;
    logic [2:0]  val_idx;
    logic [31:0] rdata;

    logic [NCH-1:0] step;
    logic [NCH-1:0] advance;
    logic [NCH-1:0] restart;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] clr;
    logic [WIDTH-1:0] a_arr [NCH];

    logic unused_bits;
    assign unused_bits = ^wbs.wbs_dat_i;

    assign off     = wbs.wbs_adr_i[7:0];
    assign wdat    = wbs.wbs_dat_i;
    assign hit     = wbs.wbs_adr_i[31:8] == BASE_ADDRESS[31:8];
    assign accept  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    // Partial-word writes are acked but have no effect.
    assign wr_en   = accept & wbs.wbs_we_i & hit
                   & (wbs.wbs_sel_i == 4'hF);
    assign val_hit = (off[7:5] == OFF_VAL[7:5]) && (off[1:0] == 2'b00);
    assign val_idx = off[4:2];

    // A step only matters for a stopped channel; running ones advance anyway.
    assign step    = (wr_en && off == OFF_STEP) ? wdat[NCH-1:0] & ~run_q
                                                : '0;
    assign advance = run_q | step;
    assign clr     = (wr_en && off == OFF_IRQ_STAT) ? wdat[NCH-1:0] : '0;

    always_comb begin
        restart = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_en && val_hit && val_idx == 3'(i)) begin
                restart[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        fib_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .advance   (advance[g]),
            .restart   (restart[g]),
            .a         (a_arr[g]),
            .ovf_pulse (ovf[g])
        );
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_ID:       rdata = ID;
                OFF_INFO:     rdata = {16'(NCH), 16'(WIDTH)};
                OFF_CTRL:     rdata = 32'(run_q);
                OFF_IRQ_EN:   rdata = 32'(irq_en_q);
                OFF_IRQ_STAT: rdata = 32'(stat_q);
                OFF_OUTSEL:   rdata = 32'(outsel_q);
                default:      rdata = '0;
            endcase
            for (int i = 0; i < NCH; i++) begin
                if (val_hit && val_idx == 3'(i)) begin
                    rdata = 32'(a_arr[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            run_q    <= '0;
            irq_en_q <= '0;
            stat_q   <= '0;
            outsel_q <= '0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                dat_q <= wbs.wbs_we_i ? 32'h0 : rdata;
            end
            if (wr_en && off == OFF_CTRL) begin
                run_q <= wdat[NCH-1:0];
            end
            if (wr_en && off == OFF_IRQ_EN) begin
                irq_en_q <= wdat[NCH-1:0];
            end
            if (wr_en && off == OFF_OUTSEL) begin
                outsel_q <= wdat[OUTSEL_W-1:0];
            end
            // A fresh overflow wins over a clear of the same bit.
            stat_q <= (stat_q & ~clr) | ovf;
        end
    end

    always_comb begin
        value_o = '0;
        for (int i = 0; i < NCH; i++) begin
            if (outsel_q == OUTSEL_W'(i)) begin
                value_o = a_arr[i];
            end
        end
    end

    assign irq_o         = |(stat_q & irq_en_q);
    assign run_o         = run_q;
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

endmodule
